// File: rtl/vga_box_render.sv
// vga_box_render: two-stage pixel pipeline drawing a bordered square that bounces one step per frame.
module vga_box_render #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP = 2,
  parameter logic [2:0] BG_COLOR = 3'b001,
  parameter logic [2:0] BOX_COLOR = 3'b010,
  parameter logic [2:0] BRD_COLOR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       run,
  input  logic       restart,
  output logic [2:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);
  localparam logic [9:0] X0 = 10'((H_MAX - BOX_SIZE) / 2);
  localparam logic [9:0] Y0 = 10'((V_MAX - BOX_SIZE) / 2);
  localparam logic [9:0] X_LIM = 10'(H_MAX - BOX_SIZE);
  localparam logic [9:0] Y_LIM = 10'(V_MAX - BOX_SIZE);
  localparam logic [10:0] SIZE11 = 11'(BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [9:0] px_s1_q, py_s1_q, bx_q, bx_d, by_q, by_d;
  logic von_s1_q, hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q, ft_q, ft_d, dx_q, dx_d, dy_q, dy_d;
  logic [2:0] rgb_q, rgb_d;
  logic [10:0] x11, y11, bx11, by11, bx_end, by_end;
  logic in_box, on_brd, hit_r, hit_l, hit_b, hit_t;
  logic [9:0] bx_step, by_step;
  always_comb begin
    x11 = {1'b0, px_s1_q};
    y11 = {1'b0, py_s1_q};
    bx11 = {1'b0, bx_q};
    by11 = {1'b0, by_q};
    bx_end = bx11 + SIZE11;
    by_end = by11 + SIZE11;
    in_box = x11 >= bx11 && x11 < bx_end && y11 >= by11 && y11 < by_end;
    on_brd = x11 == bx11 || x11 == bx_end - 11'd1 || y11 == by11 || y11 == by_end - 11'd1;
    rgb_d = !von_s1_q ? 3'b000 : in_box ? (on_brd ? BRD_COLOR : BOX_COLOR) : BG_COLOR;
    ft_d = p_tick && pixel_x == 10'd0 && pixel_y == 10'(V_MAX);
  end
  // Bounce clamps the box flush against the edge instead of overshooting it.
  always_comb begin
    hit_r = bx_end + STEP11 >= 11'(H_MAX);
    hit_b = by_end + STEP11 >= 11'(V_MAX);
    hit_l = bx11 <= STEP11;
    hit_t = by11 <= STEP11;
    bx_step = dx_q ? (hit_r ? X_LIM : bx_q + 10'(STEP)) : (hit_l ? 10'd0 : bx_q - 10'(STEP));
    by_step = dy_q ? (hit_b ? Y_LIM : by_q + 10'(STEP)) : (hit_t ? 10'd0 : by_q - 10'(STEP));
  end
  always_comb begin
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (restart || state_q == IDLE) begin
      bx_d = X0;
      by_d = Y0;
      dx_d = 1'b1;
      dy_d = 1'b1;
    end
    if (restart) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = run ? RUN : IDLE;
        RUN: begin
          state_d = run ? RUN : HOLD;
          if (ft_q) begin
            bx_d = bx_step;
            by_d = by_step;
            dx_d = dx_q ? !hit_r : hit_l;
            dy_d = dy_q ? !hit_b : hit_t;
          end
        end
        HOLD: state_d = run ? RUN : HOLD;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      px_s1_q <= '0;
      py_s1_q <= '0;
      von_s1_q <= 1'b0;
      hs_s1_q <= 1'b0;
      vs_s1_q <= 1'b0;
      rgb_q <= '0;
      hs_s2_q <= 1'b0;
      vs_s2_q <= 1'b0;
      ft_q <= 1'b0;
      bx_q <= X0;
      by_q <= Y0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
      state_q <= IDLE;
    end else begin
      px_s1_q <= pixel_x;
      py_s1_q <= pixel_y;
      von_s1_q <= video_on;
      hs_s1_q <= hsync_in;
      vs_s1_q <= vsync_in;
      rgb_q <= rgb_d;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
      ft_q <= ft_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      state_q <= state_d;
    end
  end
  assign rgb = rgb_q;
  assign hsync_out = hs_s2_q;
  assign vsync_out = vs_s2_q;
  assign frame_tick = ft_q;
  assign box_x = bx_q;
  assign box_y = by_q;
endmodule

// File: tb/tb_vga_box_render.sv
// tb_vga_box_render: random and directed stimulus checked each cycle against a behavioural model.
module tb_vga_box_render;
  logic clk = 0, reset = 1, p_tick = 0, video_on = 0, hsync_in = 0, vsync_in = 0, run = 0, restart = 0;
  logic [9:0] pixel_x = 0, pixel_y = 0;
  logic [2:0] rgb;
  logic hsync_out, vsync_out, frame_tick;
  logic [9:0] box_x, box_y;
  int checks = 0, errors = 0;
  vga_box_render dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .run(run), .restart(restart),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick),
    .box_x(box_x), .box_y(box_y)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int colour(input int x, input int y, input bit v, input int bx, input int by);
    if (!v) return 0;
    if (x >= bx && x < bx + 32 && y >= by && y < by + 32)
      return (x == bx || x == bx + 31 || y == by || y == by + 31) ? 7 : 2;
    return 1;
  endfunction
  // Reference: box position as plain integers, pipeline as one stage of remembered inputs.
  int m_bx, m_by, m_dx, m_dy, s1_x, s1_y, exp_rgb;
  bit m_ok = 0, m_moving, m_held, s1_v, s1_h, s1_vs, exp_h, exp_vs, exp_ft;
  always @(posedge clk) begin
    if (reset) begin
      {s1_x, s1_y, exp_rgb} = 0;
      {s1_v, s1_h, s1_vs, exp_h, exp_vs, exp_ft, m_moving, m_held} = 0;
      m_bx = 304; m_by = 224; m_dx = 1; m_dy = 1; m_ok = 1;
    end else begin
      exp_rgb = colour(s1_x, s1_y, s1_v, m_bx, m_by);
      exp_h = s1_h; exp_vs = s1_vs;
      s1_x = pixel_x; s1_y = pixel_y; s1_v = video_on; s1_h = hsync_in; s1_vs = vsync_in;
      if (restart) begin
        m_bx = 304; m_by = 224; m_dx = 1; m_dy = 1; m_moving = 0; m_held = 0;
      end else begin
        if (m_moving && exp_ft) begin
          if (m_dx > 0) begin
            if (m_bx + 34 >= 640) begin m_bx = 608; m_dx = -1; end else m_bx += 2;
          end else begin
            if (m_bx <= 2) begin m_bx = 0; m_dx = 1; end else m_bx -= 2;
          end
          if (m_dy > 0) begin
            if (m_by + 34 >= 480) begin m_by = 448; m_dy = -1; end else m_by += 2;
          end else begin
            if (m_by <= 2) begin m_by = 0; m_dy = 1; end else m_by -= 2;
          end
        end
        if (run) begin m_moving = 1; m_held = 0; end
        else if (m_moving || m_held) begin m_moving = 0; m_held = 1; end
      end
      exp_ft = p_tick && pixel_x == 0 && pixel_y == 480;
    end
  end
  always @(negedge clk) if (m_ok) begin
    check("rgb", rgb, exp_rgb);
    check("hsync_out", hsync_out, exp_h);
    check("vsync_out", vsync_out, exp_vs);
    check("frame_tick", frame_tick, exp_ft);
    check("box_x", box_x, m_bx);
    check("box_y", box_y, m_by);
  end
  task automatic rand_pix();
    int bx = m_bx + $urandom_range(0, 35) - 2;
    int by = m_by + $urandom_range(0, 35) - 2;
    if ($urandom_range(0, 1)) begin bx = $urandom_range(0, 639); by = $urandom_range(0, 479); end
    pixel_x = 10'(bx < 0 ? 0 : bx);
    pixel_y = 10'(by < 0 ? 0 : by);
    p_tick = 1'($urandom); video_on = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
  endtask
  task automatic tick();
    @(negedge clk); rand_pix(); p_tick = 1; pixel_x = 0; pixel_y = 480;
    @(negedge clk); rand_pix();
    @(negedge clk);
  endtask
  initial begin
    repeat (2) begin @(negedge clk); rand_pix(); end
    @(negedge clk);
    check("t1_rgb", rgb, 0); check("t1_hs", hsync_out, 0); check("t1_ft", frame_tick, 0);
    check("t1_bx", box_x, 304); check("t1_by", box_y, 224);
    reset = 0;
    pixel_x = 304; pixel_y = 224; video_on = 1; hsync_in = 1; vsync_in = 0; p_tick = 1;
    @(negedge clk); pixel_x = 305; pixel_y = 225; hsync_in = 0;
    @(negedge clk); check("t2_brd", rgb, 7); check("t2_hs", hsync_out, 1); pixel_x = 0; pixel_y = 0;
    @(negedge clk); check("t2_box", rgb, 2); check("t2_hs0", hsync_out, 0); video_on = 0;
    @(negedge clk); check("t2_bg", rgb, 1);
    @(negedge clk); check("t2_off", rgb, 0);
    run = 1;
    tick(); check("t3_bx", box_x, 306); check("t3_by", box_y, 226);
    run = 0;
    tick(); tick(); check("t3_hold_bx", box_x, 306); check("t3_hold_by", box_y, 226);
    run = 1;
    for (int k = 2; k <= 457; k++) begin
      tick();
      case (k)
        111: check("t4_by446", box_y, 446);
        112: check("t4_by448", box_y, 448);
        113: check("t4_by_back", box_y, 446);
        151: check("t4_bx606", box_x, 606);
        152: check("t4_bx608", box_x, 608);
        153: check("t4_bx_back", box_x, 606);
        335: check("t5_by2", box_y, 2);
        336: check("t5_by0", box_y, 0);
        337: check("t5_by_fwd", box_y, 2);
        455: check("t5_bx2", box_x, 2);
        456: check("t5_bx0", box_x, 0);
        457: check("t5_bx_fwd", box_x, 2);
        default: ;
      endcase
    end
    @(negedge clk); rand_pix(); p_tick = 1; pixel_x = 0; pixel_y = 480;
    @(negedge clk); rand_pix(); restart = 1; check("t6_ft", frame_tick, 1);
    @(negedge clk); restart = 0; check("t6_bx", box_x, 304); check("t6_by", box_y, 224);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rand_pix();
      if ($urandom_range(0, 7) == 0) begin p_tick = 1; pixel_x = 0; pixel_y = 480; end
      run = $urandom_range(0, 31) != 0;
      restart = $urandom_range(0, 299) == 0;
      reset = $urandom_range(0, 1999) == 0;
    end
    @(negedge clk); reset = 0; restart = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
